// File: rtl/dlx_mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of one single-ported unified memory.
// Optional build macro DLX_MEM_WATCH_EN adds watch_addr_o/watch_data_o (last committed write).
module dlx_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int WAIT   = 1
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  output logic              busy_o
`ifdef DLX_MEM_WATCH_EN
  ,
  output logic [ADDR_W-1:0] watch_addr_o,
  output logic [DATA_W-1:0] watch_data_o
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  // state  | meaning
  // IDLE   | sample requests, arbitrate
  // ACCESS | count down extra wait cycles; memory op on exit edge
  // RESP   | ack pulse to the winning port, rdata valid
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state, state_nxt;
  logic              start, take_dm, commit;
  logic              grant_dm, last_dm, we_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wait_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

`ifdef DLX_MEM_WATCH_EN
  logic [ADDR_W-1:0] addr_q;
`endif

  // Address bits outside the word index are deliberately ignored (wrap-around).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr_i[ADDR_W-1:IDX_W+2], if_addr_i[1:0],
                              dm_addr_i[ADDR_W-1:IDX_W+2], dm_addr_i[1:0]};

  always_ff @(posedge clock_i) begin
    if (!reset_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    // Round robin: on a tie the port not granted last time wins.
    take_dm   = dm_req_i && (!if_req_i || !last_dm);
    case (state)
      IDLE: begin
        if (if_req_i || dm_req_i) begin
          start     = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS:  if (wait_cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign commit   = (state == ACCESS) && (wait_cnt == 4'd0);
  assign if_ack_o = (state == RESP) && !grant_dm;
  assign dm_ack_o = (state == RESP) && grant_dm;
  assign busy_o   = (state != IDLE);

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      grant_dm     <= 1'b0;
      last_dm      <= 1'b0;
      we_q         <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      wait_cnt     <= '0;
      if_rdata_o   <= '0;
      dm_rdata_o   <= '0;
`ifdef DLX_MEM_WATCH_EN
      addr_q       <= '0;
      watch_addr_o <= '0;
      watch_data_o <= '0;
`endif
    end else begin
      if (start) begin
        grant_dm <= take_dm;
        last_dm  <= take_dm;
        we_q     <= take_dm && dm_we_i;
        idx_q    <= take_dm ? dm_addr_i[IDX_W+1:2] : if_addr_i[IDX_W+1:2];
        wdata_q  <= dm_wdata_i;
        wait_cnt <= 4'(WAIT);
`ifdef DLX_MEM_WATCH_EN
        addr_q   <= take_dm ? dm_addr_i : if_addr_i;
`endif
      end
      if (state == ACCESS && wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
      if (commit) begin
        if (grant_dm) dm_rdata_o <= we_q ? wdata_q : mem[idx_q];
        else          if_rdata_o <= mem[idx_q];
`ifdef DLX_MEM_WATCH_EN
        if (we_q) begin
          watch_addr_o <= addr_q;
          watch_data_o <= wdata_q;
        end
`endif
      end
    end
  end

  // Array is never cleared; a write colliding with reset is dropped.
  always_ff @(posedge clock_i) begin
    if (reset_i && commit && we_q) mem[idx_q] <= wdata_q;
  end

endmodule

// File: tb/tb_dlx_mem_arbiter.sv
// Directed self-checking bench for dlx_mem_arbiter: one instance with WAIT=1, one with WAIT=0.
module tb_dlx_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  int          n_checks = 0;
  int          n_fail   = 0;

  logic        if_req, dm_req, dm_we, if_ack, dm_ack, busy;
  logic [31:0] if_addr, dm_addr, dm_wdata, if_rdata, dm_rdata;
  logic        z_if_req, z_dm_req, z_dm_we, z_if_ack, z_dm_ack, z_busy;
  logic [31:0] z_if_addr, z_dm_addr, z_dm_wdata, z_if_rdata, z_dm_rdata;
`ifdef DLX_MEM_WATCH_EN
  logic [31:0] watch_addr, watch_data, z_watch_addr, z_watch_data;
`endif

  always #5 clk = ~clk;

  dlx_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(1024), .WAIT(1)) dut (
    .clock_i(clk), .reset_i(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ack_o(if_ack),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_rdata_o(dm_rdata), .dm_ack_o(dm_ack), .busy_o(busy)
`ifdef DLX_MEM_WATCH_EN
    , .watch_addr_o(watch_addr), .watch_data_o(watch_data)
`endif
  );

  dlx_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(1024), .WAIT(0)) dut0 (
    .clock_i(clk), .reset_i(rst_n),
    .if_req_i(z_if_req), .if_addr_i(z_if_addr), .if_rdata_o(z_if_rdata), .if_ack_o(z_if_ack),
    .dm_req_i(z_dm_req), .dm_we_i(z_dm_we), .dm_addr_i(z_dm_addr), .dm_wdata_i(z_dm_wdata),
    .dm_rdata_o(z_dm_rdata), .dm_ack_o(z_dm_ack), .busy_o(z_busy)
`ifdef DLX_MEM_WATCH_EN
    , .watch_addr_o(z_watch_addr), .watch_data_o(z_watch_data)
`endif
  );

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Data access on the WAIT=1 instance; lat = edges until dm_ack seen (99 = timeout).
  task automatic do_dm(input logic we, input logic [31:0] a, input logic [31:0] d,
                       output int lat);
    dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = d;
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (dm_ack) begin lat = i; break; end
    end
    dm_req = 1'b0;
  endtask

  task automatic do_if(input logic [31:0] a, output int lat);
    if_req = 1'b1; if_addr = a;
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (if_ack) begin lat = i; break; end
    end
    if_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_checks++; if (if_ack !== 1'b0) begin n_fail++; $display("FAIL reset_if_ack got %b exp 0", if_ack); end
    n_checks++; if (dm_ack !== 1'b0) begin n_fail++; $display("FAIL reset_dm_ack got %b exp 0", dm_ack); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (if_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_if_rdata got %h exp 0", if_rdata); end
    n_checks++; if (dm_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_dm_rdata got %h exp 0", dm_rdata); end
    n_checks++; if (z_busy !== 1'b0) begin n_fail++; $display("FAIL reset_z_busy got %b exp 0", z_busy); end
`ifdef DLX_MEM_WATCH_EN
    n_checks++; if (watch_addr !== 32'h0) begin n_fail++; $display("FAIL reset_watch_addr got %h exp 0", watch_addr); end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_fetch();
    int lat;
    do_dm(1'b1, 32'h10, 32'hDEADBEEF, lat);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL wr_latency got %0d exp 3", lat); end
    n_checks++; if (dm_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_echo got %h exp deadbeef", dm_rdata); end
`ifdef DLX_MEM_WATCH_EN
    n_checks++; if (watch_addr !== 32'h10 || watch_data !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL watch_wr got %h/%h exp 10/deadbeef", watch_addr, watch_data); end
`endif
    tick();
    n_checks++; if (dm_ack !== 1'b0) begin n_fail++; $display("FAIL dm_ack_pulse got %b exp 0", dm_ack); end
    do_if(32'h10, lat);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL if_latency got %0d exp 3", lat); end
    n_checks++; if (if_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL if_rdata got %h exp deadbeef", if_rdata); end
    tick();
    n_checks++; if (if_ack !== 1'b0) begin n_fail++; $display("FAIL if_ack_pulse got %b exp 0", if_ack); end
    n_checks++; if (if_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL if_rdata_hold got %h exp deadbeef", if_rdata); end
  endtask

  task automatic test_round_robin();
    int lat, t_dm, t_if;
    logic both;
    do_dm(1'b1, 32'h0, 32'h11111111, lat); tick();
    do_dm(1'b1, 32'h4, 32'h22222222, lat); tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0;
    if_req = 1'b1; if_addr = 32'h4;
    t_dm = 99; t_if = 99; both = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (dm_ack && if_ack) both = 1'b1;
      if (dm_ack && t_dm == 99) begin t_dm = i; dm_req = 1'b0; end
      if (if_ack && t_if == 99) begin t_if = i; if_req = 1'b0; end
      if (t_dm != 99 && t_if != 99) break;
    end
    dm_req = 1'b0; if_req = 1'b0;
    n_checks++; if (t_dm !== 3) begin n_fail++; $display("FAIL rr_dm_first got %0d exp 3", t_dm); end
    n_checks++; if (t_if !== 7) begin n_fail++; $display("FAIL rr_if_second got %0d exp 7", t_if); end
    n_checks++; if (both !== 1'b0) begin n_fail++; $display("FAIL rr_overlap got %b exp 0", both); end
    n_checks++; if (dm_rdata !== 32'h11111111) begin n_fail++; $display("FAIL rr_dm_rdata got %h exp 11111111", dm_rdata); end
    n_checks++; if (if_rdata !== 32'h22222222) begin n_fail++; $display("FAIL rr_if_rdata got %h exp 22222222", if_rdata); end
    tick();
  endtask

  task automatic test_wrap();
    int lat;
    do_dm(1'b1, 32'h1000, 32'h55, lat); tick();
    do_dm(1'b0, 32'h0, 32'h0, lat); tick();
    n_checks++; if (dm_rdata !== 32'h55) begin n_fail++; $display("FAIL wrap_read got %h exp 55", dm_rdata); end
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    logic b1, b4;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h10;
    t1 = 99; t2 = 99; b1 = 1'bx; b4 = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 1) b1 = busy;
      if (i == 4) b4 = busy;
      if (dm_ack) begin
        if (t1 == 99) t1 = i;
        else begin t2 = i; break; end
      end
    end
    dm_req = 1'b0;
    n_checks++; if (t2 - t1 !== 4) begin n_fail++; $display("FAIL b2b_period got %0d exp 4", t2 - t1); end
    n_checks++; if (b1 !== 1'b1) begin n_fail++; $display("FAIL busy_access got %b exp 1", b1); end
    n_checks++; if (b4 !== 1'b0) begin n_fail++; $display("FAIL busy_idle got %b exp 0", b4); end
    tick();
  endtask

  task automatic test_reset_commit();
    int lat;
    logic seen;
    do_dm(1'b1, 32'h20, 32'hA5A5A5A5, lat); tick();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'h12345678;
    tick(); seen = dm_ack;
    tick(); seen = seen | dm_ack;
    rst_n = 1'b0;
    tick(); seen = seen | dm_ack;
    dm_req = 1'b0;
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rc_no_ack got %b exp 0", seen); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rc_busy got %b exp 0", busy); end
    n_checks++; if (dm_rdata !== 32'h0 || if_rdata !== 32'h0) begin
      n_fail++; $display("FAIL rc_rdata got %h/%h exp 0/0", dm_rdata, if_rdata); end
    rst_n = 1'b1; tick();
    do_dm(1'b0, 32'h20, 32'h0, lat); tick();
    n_checks++; if (dm_rdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL rc_word_kept got %h exp a5a5a5a5", dm_rdata); end
  endtask

  task automatic test_wait0();
    z_dm_req = 1'b1; z_dm_we = 1'b1; z_dm_addr = 32'h44; z_dm_wdata = 32'hCAFEF00D;
    tick();
    z_dm_req = 1'b0;
    n_checks++; if (z_dm_ack !== 1'b0) begin n_fail++; $display("FAIL w0_early_ack got %b exp 0", z_dm_ack); end
    tick();
    n_checks++; if (z_dm_ack !== 1'b1) begin n_fail++; $display("FAIL w0_ack got %b exp 1", z_dm_ack); end
    n_checks++; if (z_dm_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL w0_echo got %h exp cafef00d", z_dm_rdata); end
    tick();
    n_checks++; if (z_dm_ack !== 1'b0 || z_busy !== 1'b0) begin
      n_fail++; $display("FAIL w0_done got ack %b busy %b exp 0 0", z_dm_ack, z_busy); end
`ifdef DLX_MEM_WATCH_EN
    n_checks++; if (z_watch_addr !== 32'h44 || z_watch_data !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL w0_watch got %h/%h exp 44/cafef00d", z_watch_addr, z_watch_data); end
`endif
    z_if_req = 1'b1; z_if_addr = 32'h44;
    tick(); tick();
    z_if_req = 1'b0;
    n_checks++; if (z_if_ack !== 1'b1) begin n_fail++; $display("FAIL w0_if_ack got %b exp 1", z_if_ack); end
    n_checks++; if (z_if_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL w0_if_rdata got %h exp cafef00d", z_if_rdata); end
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    z_if_req = 1'b0; z_if_addr = '0; z_dm_req = 1'b0; z_dm_we = 1'b0; z_dm_addr = '0; z_dm_wdata = '0;
    test_reset();
    test_write_fetch();
    test_round_robin();
    test_wrap();
    test_back_to_back();
    test_reset_commit();
    test_wait0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
